// File: rtl/pattern_sequencer.sv
// pattern_sequencer: selects the test pattern code, stepping it manually on debounced
// button presses or automatically every FRAMES_PER_PATTERN frames, always on a frame boundary.
module pattern_sequencer #(
  parameter int NUM_PATTERNS       = 5,
  parameter int FRAMES_PER_PATTERN = 120,
  parameter int DEBOUNCE_CYCLES    = 250000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_vsync,
  input  logic       i_btn_next,
  input  logic       i_auto_en,
  output logic [2:0] o_pattern,
  output logic       o_frame_tick,
  output logic       o_auto_active
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [2:0]    LAST  = 3'(NUM_PATTERNS - 1);
  localparam logic [9:0]    FLAST = 10'(FRAMES_PER_PATTERN - 1);
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic {MANUAL, AUTO} state_t;
  state_t        state_q;
  logic [2:0]    vs_q;
  logic [1:0]    bt_q, ae_q;
  logic [DW-1:0] db_cnt_q;
  logic          db_q, db_prev_q, tick_q, pend_q;
  logic [2:0]    pattern_q, man_d, auto_d;
  logic [9:0]    fcnt_q;
  logic          press;
  assign press         = db_q & ~db_prev_q;
  assign o_pattern     = pattern_q;
  assign o_frame_tick  = tick_q;
  assign o_auto_active = (state_q == AUTO);
  always_comb begin
    man_d  = (pattern_q == LAST) ? 3'd0 : pattern_q + 3'd1;
    auto_d = (pattern_q == LAST || pattern_q == 3'd0) ? 3'd1 : pattern_q + 3'd1;
  end
  // vs_q[2] is the previous synchronized vsync, used for rising-edge detection
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vs_q   <= '0;
      bt_q   <= '0;
      ae_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      vs_q   <= {vs_q[1:0], i_vsync};
      bt_q   <= {bt_q[0], i_btn_next};
      ae_q   <= {ae_q[0], i_auto_en};
      tick_q <= vs_q[1] & ~vs_q[2];
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      db_cnt_q  <= '0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
    end else begin
      db_prev_q <= db_q;
      if (bt_q[1] == db_q) db_cnt_q <= '0;
      else if (db_cnt_q == DLAST) begin
        db_q     <= bt_q[1];
        db_cnt_q <= '0;
      end else db_cnt_q <= db_cnt_q + 1'b1;
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= MANUAL;
      pattern_q <= '0;
      pend_q    <= 1'b0;
      fcnt_q    <= '0;
    end else if (state_q == MANUAL) begin
      if (ae_q[1]) begin
        state_q <= AUTO;
        pend_q  <= 1'b0;
        fcnt_q  <= '0;
      end else if (tick_q && pend_q) begin
        pattern_q <= man_d;
        pend_q    <= press;
      end else if (press) pend_q <= 1'b1;
    end else begin
      if (!ae_q[1]) begin
        state_q <= MANUAL;
        fcnt_q  <= '0;
      end else if (tick_q) begin
        // a disabled generator (code 0) jumps straight to 1 and restarts the dwell
        if (pattern_q == 3'd0 || fcnt_q == FLAST) begin
          pattern_q <= auto_d;
          fcnt_q    <= '0;
        end else fcnt_q <= fcnt_q + 10'd1;
      end
    end
  end
endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: random vsync/button/auto/reset stimulus checked every cycle
// against a history-based reference model of the sequencer.
module tb_pattern_sequencer;
  localparam int N = 5, FPP = 2, DB = 8;
  logic clk = 0, rst_n = 0, vsync = 0, btn = 0, auto_en = 0;
  logic [2:0] pattern;
  logic tick, auto_act;
  int n_tests = 0, n_fail = 0;
  bit hv[4];
  bit hb[DB+2];
  bit ha[3];
  bit m_tick, m_auto, m_pend, m_db, m_press;
  int m_pat, m_frames;
  pattern_sequencer #(.NUM_PATTERNS(N), .FRAMES_PER_PATTERN(FPP), .DEBOUNCE_CYCLES(DB)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_vsync(vsync), .i_btn_next(btn), .i_auto_en(auto_en),
    .o_pattern(pattern), .o_frame_tick(tick), .o_auto_active(auto_act)
  );
  always #20 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  // inputs are sampled per edge into histories; index j = sample taken j edges ago
  task automatic model_step();
    bit all_diff, rose, t_in, p_in, a_in;
    if (!rst_n) begin
      hv = '{default: 0};
      hb = '{default: 0};
      ha = '{default: 0};
      m_tick = 0; m_auto = 0; m_pend = 0; m_db = 0; m_press = 0; m_pat = 0; m_frames = 0;
      return;
    end
    for (int j = 3; j > 0; j--) hv[j] = hv[j-1];
    for (int j = DB + 1; j > 0; j--) hb[j] = hb[j-1];
    for (int j = 2; j > 0; j--) ha[j] = ha[j-1];
    hv[0] = vsync; hb[0] = btn; ha[0] = auto_en;
    t_in = m_tick; p_in = m_press; a_in = ha[2];
    m_tick = hv[2] & ~hv[3];
    all_diff = 1;
    for (int j = 2; j <= DB + 1; j++) if (hb[j] == m_db) all_diff = 0;
    rose = 0;
    if (all_diff) begin
      m_db = ~m_db;
      rose = m_db;
    end
    m_press = rose;
    if (!m_auto) begin
      if (a_in) begin
        m_auto = 1; m_pend = 0; m_frames = 0;
      end else if (t_in && m_pend) begin
        m_pat = (m_pat + 1) % N;
        m_pend = p_in;
      end else if (p_in) m_pend = 1;
    end else if (!a_in) begin
      m_auto = 0; m_frames = 0;
    end else if (t_in) begin
      if (m_pat == 0) begin
        m_pat = 1; m_frames = 0;
      end else if (m_frames == FPP - 1) begin
        m_pat = m_pat % (N - 1) + 1; m_frames = 0;
      end else m_frames++;
    end
  endtask
  initial begin
    int fc = 0, per = 20, bmode = 0, bleft = 0, aleft = 0, rleft = 3;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("pattern", 32'(pattern), 32'(m_pat));
      check("frame_tick", 32'(tick), 32'(m_tick));
      check("auto_active", 32'(auto_act), 32'(m_auto));
      check("pattern_range", 32'(pattern < 3'(N)), 32'd1);
      rst_n = (rleft == 0);
      if (rleft > 0) rleft--;
      else if ($urandom_range(0, 2999) == 0) rleft = $urandom_range(1, 3);
      vsync = (fc < 3);
      fc++;
      if (fc >= per) begin
        fc = 0;
        per = $urandom_range(10, 40);
      end
      if (bleft == 0) begin
        bmode = $urandom_range(0, 2);
        bleft = $urandom_range(5, 60);
      end
      bleft--;
      btn = (bmode == 0) ? 1'b0 : (bmode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      if (aleft == 0) begin
        auto_en = ($urandom_range(0, 2) == 0);
        aleft = $urandom_range(20, 600);
      end
      aleft--;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
